// File: rtl/gem_tx_frame_shaper.sv
// ---------------------------------------------------------------------------
// gem_tx_frame_shaper
//   Enforces the Ethernet length window on AXI-Stream Tx frames ahead of the
//   Tx frame FIFO. Runts are zero-padded up to MIN_LEN bytes. Giants are cut
//   at MAX_LEN bytes, flagged bad, and their remaining input is swallowed.
//   Any input tuser seen in a frame marks that frame bad on its last beat.
//
// Ports
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   s_axis_*            byte-wide AXI-Stream slave (tuser = bad byte/frame)
//   m_axis_*            byte-wide AXI-Stream master, one register stage;
//                       tuser is meaningful only with tlast
//   stat_pad            one-cycle pulse when a runt is accepted and padding starts
//   stat_trunc          one-cycle pulse when a giant is cut
// ---------------------------------------------------------------------------
module gem_tx_frame_shaper #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic       m_axis_tready,
    output logic       stat_pad,
    output logic       stat_trunc
);

    localparam logic [10:0] MIN_M1 = 11'(MIN_LEN - 1);
    localparam logic [10:0] MAX_M1 = 11'(MAX_LEN - 1);

    typedef enum logic [1:0] {PASS, PAD, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic [10:0] cnt_q, cnt_d;      // output beats already emitted for this frame
    logic        err_q, err_d;      // sticky bad-frame flag
    logic        out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PASS;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            cnt_q    <= 11'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        s_axis_tready = 1'b0;
        stat_pad      = 1'b0;
        stat_trunc    = 1'b0;

        // Register can take a new beat when empty or being drained this cycle.
        out_free = !tvalid_q || m_axis_tready;
        if (out_free) tvalid_d = 1'b0;

        if (!rst) begin
            unique case (state_q)
                PASS: begin
                    s_axis_tready = out_free;
                    if (s_axis_tvalid && out_free) begin
                        tvalid_d = 1'b1;
                        tdata_d  = s_axis_tdata;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                        // Last-beat check comes first so a frame of exactly
                        // MAX_LEN bytes closes normally instead of truncating.
                        if (s_axis_tlast && cnt_q >= MIN_M1) begin
                            tlast_d = 1'b1;
                            tuser_d = err_q | s_axis_tuser;
                            cnt_d   = 11'd0;
                            err_d   = 1'b0;
                        end else if (s_axis_tlast) begin
                            cnt_d    = cnt_q + 11'd1;
                            err_d    = err_q | s_axis_tuser;
                            state_d  = PAD;
                            stat_pad = 1'b1;
                        end else if (cnt_q == MAX_M1) begin
                            tlast_d    = 1'b1;
                            tuser_d    = 1'b1;
                            cnt_d      = 11'd0;
                            err_d      = 1'b0;
                            state_d    = DISCARD;
                            stat_trunc = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 11'd1;
                            err_d = err_q | s_axis_tuser;
                        end
                    end
                end
                PAD: begin
                    if (out_free) begin
                        tvalid_d = 1'b1;
                        tdata_d  = 8'h00;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                        if (cnt_q == MIN_M1) begin
                            tlast_d = 1'b1;
                            tuser_d = err_q;
                            cnt_d   = 11'd0;
                            err_d   = 1'b0;
                            state_d = PASS;
                        end else begin
                            cnt_d = cnt_q + 11'd1;
                        end
                    end
                end
                DISCARD: begin
                    // Tail of a truncated frame: sink without touching output.
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) state_d = PASS;
                end
                default: state_d = PASS;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_gem_tx_frame_shaper.sv
// ---------------------------------------------------------------------------
// tb_gem_tx_frame_shaper
//   Directed bench: frames are pushed through the shaper, an independent
//   length-window model builds the expected output beats, and a monitor
//   collects actual beats, stat pulses and checks stall stability.
// ---------------------------------------------------------------------------
module tb_gem_tx_frame_shaper;

    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic       stat_pad, stat_trunc;

    always #5 clk = ~clk;

    gem_tx_frame_shaper #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .stat_pad      (stat_pad),
        .stat_trunc    (stat_trunc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // beat = {tlast, tuser, tdata}
    logic [9:0] out_q[$];
    logic [9:0] exp_q[$];
    int         pad_seen   = 0;
    int         trunc_seen = 0;
    bit         rand_ready = 1'b0;

    // Sink ready: always 1, or coin-flip backpressure.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: collect accepted beats, stat pulses, stall stability.
    initial begin
        logic [9:0] prev;
        bit         prev_stall;
        prev       = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_vld", m_axis_tvalid, 1'b1);
                    check("stall_hold", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, prev);
                end
                if (m_axis_tvalid && m_axis_tready)
                    out_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
                if (stat_pad)   pad_seen++;
                if (stat_trunc) trunc_seen++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev       = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
            end
        end
    end

    // Reference model: length window applied to one input frame.
    task automatic add_exp(input int len, input int base, input int bad_idx);
        int  n_out;
        bit  bad;
        logic [7:0] d;
        n_out = (len > MAX_LEN) ? MAX_LEN : ((len < MIN_LEN) ? MIN_LEN : len);
        bad   = (len > MAX_LEN) || (bad_idx >= 0 && bad_idx < len);
        for (int i = 0; i < n_out; i++) begin
            d = (i < len) ? 8'(base + i) : 8'h00;
            if (i == n_out - 1) exp_q.push_back({1'b1, bad, d});
            else                exp_q.push_back({1'b0, 1'b0, d});
        end
    endtask

    task automatic send_frame(input int len, input int base, input int bad_idx);
        bit acc;
        int t;
        for (int i = 0; i < len; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(base + i);
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = (i == bad_idx);
            t = 0;
            do begin
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 1000);
            if (!acc) begin
                check("s_accept_timeout", acc, 1'b1);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drain_check(input string tag, input int epad, input int etrunc);
        int t;
        int n;
        t = 0;
        while (out_q.size() < exp_q.size() && t < 20000) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_beats"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", tag, i + 1), out_q[i], exp_q[i]);
        check({tag, "_stat_pad"}, pad_seen, epad);
        check({tag, "_stat_trunc"}, trunc_seen, etrunc);
        out_q.delete();
        exp_q.delete();
        pad_seen   = 0;
        trunc_seen = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        check({tag, "_m_tlast"},  m_axis_tlast,  1'b0);
        check({tag, "_m_tuser"},  m_axis_tuser,  1'b0);
        check({tag, "_m_tdata"},  m_axis_tdata,  8'h00);
        check({tag, "_s_tready"}, s_axis_tready, 1'b0);
        check({tag, "_stat_pad"}, stat_pad,      1'b0);
        check({tag, "_stat_trunc"}, stat_trunc,  1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 42-byte runt -> 60 beats, 18 zero pads
        add_exp(42, 1, -1);
        send_frame(42, 1, -1);
        drain_check("runt42", 1, 0);

        // 1600-byte giant -> 1514 beats, tail swallowed
        add_exp(1600, 8'h40, -1);
        send_frame(1600, 8'h40, -1);
        drain_check("giant1600", 0, 1);

        // 64-byte frame, bad byte 10
        add_exp(64, 8'h80, 9);
        send_frame(64, 8'h80, 9);
        drain_check("bad64", 0, 0);

        // exact window edges, back to back
        add_exp(60, 8'h11, -1);
        add_exp(1514, 8'h22, -1);
        send_frame(60, 8'h11, -1);
        send_frame(1514, 8'h22, -1);
        drain_check("edges", 0, 0);

        // single-beat frame, bad -> padded with tuser on last pad
        add_exp(1, 8'hA5, 0);
        send_frame(1, 8'hA5, 0);
        drain_check("single", 1, 0);

        // mixed lengths under random backpressure
        rand_ready = 1'b1;
        add_exp(1, 8'h01, -1);
        add_exp(59, 8'h30, 20);
        add_exp(60, 8'h70, -1);
        add_exp(1514, 8'h90, -1);
        add_exp(1515, 8'hC0, -1);
        send_frame(1, 8'h01, -1);
        send_frame(59, 8'h30, 20);
        send_frame(60, 8'h70, -1);
        send_frame(1514, 8'h90, -1);
        send_frame(1515, 8'hC0, -1);
        drain_check("mixed_bp", 2, 1);
        rand_ready = 1'b0;

        // reset during padding of a 10-byte frame
        send_frame(10, 8'h10, -1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("midrst");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_q.delete();
        exp_q.delete();
        pad_seen   = 0;
        trunc_seen = 0;
        add_exp(100, 8'h55, -1);
        send_frame(100, 8'h55, -1);
        drain_check("after_rst100", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gem_tx_frame_shaper.md
GEM_TX_FRAME_SHAPER -- requirements
Module: gem_tx_frame_shaper

Block sits upstream of the Tx frame FIFO feeding gem_ext_fifo_tx. It enforces the Ethernet length window on each AXI-Stream frame: pads runts, truncates giants, and flags errors via tuser.

Interface
REQ-001 Parameter MIN_LEN, default 60, minimum frame length in bytes (excluding FCS); output frames shorter than this are zero-padded.
REQ-002 Parameter MAX_LEN, default 1514, maximum frame length in bytes; longer input frames are truncated.
REQ-003 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Ports s_axis_tdata in 8, s_axis_tvalid in 1, s_axis_tlast in 1, s_axis_tuser in 1 (1 = bad byte/frame), s_axis_tready out 1: AXI-Stream slave.
REQ-006 Ports m_axis_tdata out 8, m_axis_tvalid out 1, m_axis_tlast out 1, m_axis_tuser out 1 (1 = bad frame, valid with tlast), m_axis_tready in 1: AXI-Stream master to frame FIFO.
REQ-007 Ports stat_pad out 1, stat_trunc out 1: single-cycle pulses, one per padded / truncated frame.

Function
REQ-008 Output is one register stage: m_axis_* registered; s_axis_tready = !m_axis_tvalid || m_axis_tready, forced 0 in PAD state; latency input beat to output beat is 1 cycle.
REQ-009 m_axis_* payload holds stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-010 Byte counter cnt, 11 bits, counts output beats of current frame; clears to 0 after output beat with tlast accepted into the register.
REQ-011 Sticky err flag ORs s_axis_tuser of every accepted input beat of the frame; cleared with cnt.
REQ-012 FSM states PASS, PAD, DISCARD; reset state PASS.
REQ-013 PASS: each accepted input beat is forwarded; m_axis_tuser=0 on non-last beats.
REQ-014 PASS, accepted beat with s_axis_tlast=1 and cnt >= MIN_LEN-1: forwarded with m_axis_tlast=1, m_axis_tuser = err | s_axis_tuser; stay PASS.
REQ-015 PASS, accepted beat with s_axis_tlast=1 and cnt < MIN_LEN-1: forwarded with m_axis_tlast=0; go PAD; stat_pad pulses the same cycle.
REQ-016 PAD: each cycle the output register is free, load tdata=0x00; tlast=1 and tuser=err on the beat where cnt = MIN_LEN-1, then return to PASS; input not accepted.
REQ-017 PASS, accepted beat with cnt = MAX_LEN-1 and s_axis_tlast=0: forwarded with m_axis_tlast=1, m_axis_tuser=1; go DISCARD; stat_trunc pulses.
REQ-018 Beat with cnt = MAX_LEN-1 and s_axis_tlast=1 is a legal max frame: treated as REQ-014, no truncation.
REQ-019 DISCARD: s_axis_tready=1, accepted beats are dropped, no output; on accepted s_axis_tlast=1 return to PASS.
REQ-020 A single-beat input frame (tlast on first beat) yields exactly MIN_LEN output beats.
REQ-021 Back-to-back frames: a new frame's first beat is accepted in the cycle after the previous frame's last output beat is loaded, with no idle cycle required.
REQ-022 cnt never exceeds MAX_LEN-1; no wrap-around is reachable.

Reset
REQ-023 While rst=1: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0x00, s_axis_tready=0, stat_pad=0, stat_trunc=0, cnt=0, err=0, state=PASS.
REQ-024 Reset asserted mid-frame (any state) abandons the frame; the first beat after rst deasserts starts a new frame at cnt=0.

Verification
REQ-025 42-byte frame 0x01..0x2A, tuser=0, m_tready=1 -> 60 beats: 0x01..0x2A then 18x 0x00, tlast only on beat 60, tuser=0, stat_pad one pulse.
REQ-026 1600-byte frame -> 1514 output beats, tlast+tuser=1 on beat 1514, remaining 86 input beats consumed with no output, stat_trunc one pulse.
REQ-027 64-byte frame with s_tuser=1 on byte 10 -> 64 beats unchanged, m_tuser=1 on last beat only, no stat pulses.
REQ-028 Exactly 60- and 1514-byte frames -> passed unchanged, tuser=0, no stat pulses.
REQ-029 Random m_tready backpressure (50%) over mixed 1/59/60/1514/1515-byte frames -> output byte stream equals reference model, no beat lost or duplicated, payload stable under stall.
REQ-030 rst pulsed during PAD of a 10-byte frame, then 100-byte frame sent -> outputs zero in reset, then exactly 100 beats with tlast on beat 100.
